// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC generator, in-order memory request port and a
// DEPTH-entry prefetch queue feeding decode; redirects flush queued and in-flight fetches.
module fetch_queue_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}},
  parameter int                    PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pcOpValid,
  input  logic [1:0]             pcOp,
  input  logic [ADDR_WIDTH-1:0]  pcBase,
  input  logic [ADDR_WIDTH-1:0]  pcWriteData,
  output logic                   memReqValid,
  input  logic                   memReqReady,
  output logic [ADDR_WIDTH-1:0]  memReqAddr,
  input  logic                   memRespValid,
  input  logic [INSTR_WIDTH-1:0] memRespData,
  output logic                   instrValid,
  input  logic                   instrReady,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instrPc,
  output logic [ADDR_WIDTH-1:0]  pcReadData
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]          DEPTH_W    = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0]   STEP_W     = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0]   ALIGN_MASK = ~(ADDR_WIDTH'(PC_STEP - 1));

  localparam logic [1:0] PC_CLEAR   = 2'd0;
  localparam logic [1:0] PC_ADD4    = 2'd1;
  localparam logic [1:0] PC_ADD_IMM = 2'd2;
  localparam logic [1:0] PC_SET_IMM = 2'd3;

  // Allocated entries are contiguous from head; filled entries form a prefix of them.
  logic [ADDR_WIDTH-1:0]  fetch_pc_r;
  logic [PTR_W-1:0]       head_r;
  logic [CNT_W-1:0]       alloc_cnt_r;
  logic [CNT_W-1:0]       fill_cnt_r;
  logic [CNT_W-1:0]       drop_cnt_r;
  logic [ADDR_WIDTH-1:0]  entry_pc_r   [DEPTH];
  logic [INSTR_WIDTH-1:0] entry_data_r [DEPTH];

  logic [CNT_W-1:0]      pending_s;
  logic [CNT_W-1:0]      drop_next_s;
  logic                  credit_s;
  logic                  flush_s;
  logic                  req_fire_s;
  logic                  drop_s;
  logic                  fill_s;
  logic                  pop_s;
  logic [PTR_W-1:0]      tail_idx_s;
  logic [PTR_W-1:0]      fill_idx_s;
  logic [ADDR_WIDTH-1:0] target_s;

  assign memReqValid = credit_s && !pcOpValid && reset;
  assign memReqAddr  = fetch_pc_r;
  assign pcReadData  = fetch_pc_r;
  assign instrValid  = (fill_cnt_r != {CNT_W{1'b0}}) && !pcOpValid;
  assign instr       = entry_data_r[head_r];
  assign instrPc     = entry_pc_r[head_r];

  // Queue bookkeeping, response routing and handshake events.
  always_comb begin
    pending_s  = alloc_cnt_r - fill_cnt_r;
    credit_s   = ({1'b0, alloc_cnt_r} + {1'b0, drop_cnt_r}) < DEPTH_W;
    flush_s    = pcOpValid && (pcOp != PC_ADD4);
    drop_s     = memRespValid && (drop_cnt_r != {CNT_W{1'b0}});
    fill_s     = memRespValid && (drop_cnt_r == {CNT_W{1'b0}}) && (pending_s != {CNT_W{1'b0}});
    req_fire_s = memReqValid && memReqReady;
    pop_s      = instrValid && instrReady;
    tail_idx_s = head_r + alloc_cnt_r[PTR_W-1:0];
    fill_idx_s = head_r + fill_cnt_r[PTR_W-1:0];
    // Every in-flight fetch not consumed this cycle must be discarded after a flush.
    drop_next_s = drop_cnt_r + pending_s - CNT_W'(drop_s | fill_s);
  end

  // Redirect target selection.
  always_comb begin
    target_s = {ADDR_WIDTH{1'b0}};
    case (pcOp)
      PC_CLEAR:   target_s = {ADDR_WIDTH{1'b0}};
      PC_ADD_IMM: target_s = pcBase + pcWriteData;
      PC_SET_IMM: target_s = pcWriteData;
      default:    target_s = fetch_pc_r;
    endcase
  end

  // Fetch PC: redirect to the aligned target, otherwise step on each accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
    end else if (flush_s) begin
      fetch_pc_r <= target_s & ALIGN_MASK;
    end else if (req_fire_s) begin
      fetch_pc_r <= fetch_pc_r + STEP_W;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Queue occupancy and drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r      <= {PTR_W{1'b0}};
      alloc_cnt_r <= {CNT_W{1'b0}};
      fill_cnt_r  <= {CNT_W{1'b0}};
      drop_cnt_r  <= {CNT_W{1'b0}};
    end else if (flush_s) begin
      head_r      <= head_r;
      alloc_cnt_r <= {CNT_W{1'b0}};
      fill_cnt_r  <= {CNT_W{1'b0}};
      drop_cnt_r  <= drop_next_s;
    end else begin
      head_r      <= head_r + PTR_W'(pop_s);
      alloc_cnt_r <= alloc_cnt_r + CNT_W'(req_fire_s) - CNT_W'(pop_s);
      fill_cnt_r  <= fill_cnt_r + CNT_W'(fill_s) - CNT_W'(pop_s);
      drop_cnt_r  <= drop_cnt_r - CNT_W'(drop_s);
    end
  end

  // Entry payload: PC captured on request accept, data captured on in-order fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc_r[i]   <= {ADDR_WIDTH{1'b0}};
        entry_data_r[i] <= {INSTR_WIDTH{1'b0}};
      end
    end else begin
      if (req_fire_s) begin
        entry_pc_r[tail_idx_s] <= memReqAddr;
      end
      if (fill_s) begin
        entry_data_r[fill_idx_s] <= memRespData;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam logic [31:0] TAG      = 32'hC0DE_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcOpValid;
  logic [1:0]  pcOp;
  logic [31:0] pcBase, pcWriteData;
  logic        memReqValid, memReqReady;
  logic [31:0] memReqAddr;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        instrValid, instrReady;
  logic [31:0] instr, instrPc, pcReadData;

  always #5 clk = ~clk;

  fetch_queue_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH),
                     .RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .pcOpValid(pcOpValid), .pcOp(pcOp), .pcBase(pcBase),
    .pcWriteData(pcWriteData), .memReqValid(memReqValid), .memReqReady(memReqReady),
    .memReqAddr(memReqAddr), .memRespValid(memRespValid), .memRespData(memRespData),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr), .instrPc(instrPc),
    .pcReadData(pcReadData));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
  } ent_t;

  // Reference model: queue of fetch slots, a drop counter and the memory's pending FIFO.
  logic [31:0] m_pc;
  ent_t        mq[$];
  int          m_drop;
  logic [31:0] mem_fifo[$];
  int          dut_accepts;
  logic [31:0] last_acc_addr;

  typedef struct {
    logic        ov;
    logic [1:0]  op;
    logic [31:0] base, wd;
    logic        mrdy, rv;
    logic [31:0] raddr;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ov, input logic [1:0] op, input logic [31:0] b,
                              input logic [31:0] w, input logic mr, input logic rv,
                              input logic [31:0] ra, input logic ir, input logic erv,
                              input logic [31:0] ea, input logic eiv, input logic [31:0] ep);
    vec_t v;
    v.ov = ov; v.op = op; v.base = b; v.wd = w; v.mrdy = mr; v.rv = rv; v.raddr = ra;
    v.irdy = ir; v.e_rv = erv; v.e_addr = ea; v.e_iv = eiv; v.e_ipc = ep;
    return v;
  endfunction

  task automatic model_clear();
    m_pc = RESET_PC;
    mq.delete();
    mem_fifo.delete();
    m_drop = 0;
  endtask

  // One model-checked cycle; inputs already driven at posedge+1, checks at posedge+4.
  task automatic cycle();
    bit          flush, exp_rv, exp_iv;
    logic [31:0] tgt;
    int          unfilled;
    #3;
    flush  = pcOpValid && (pcOp != 2'd1);
    exp_rv = ((mq.size() + m_drop) < DEPTH) && !pcOpValid;
    exp_iv = (mq.size() > 0) && mq[0].filled && !pcOpValid;
    chk("memReqValid", {31'd0, memReqValid}, {31'd0, exp_rv});
    chk("memReqAddr", memReqAddr, m_pc);
    chk("pcReadData", pcReadData, m_pc);
    chk("instrValid", {31'd0, instrValid}, {31'd0, exp_iv});
    if (exp_iv) begin
      chk("instrPc", instrPc, mq[0].pc);
      chk("instr", instr, mq[0].data);
    end
    if (memReqValid && memReqReady) begin
      dut_accepts++;
      last_acc_addr = memReqAddr;
    end
    if (memRespValid) begin
      if (mem_fifo.size() > 0) void'(mem_fifo.pop_front());
      if (m_drop > 0) m_drop--;
      else begin
        for (int k = 0; k < mq.size(); k++) begin
          if (!mq[k].filled) begin
            mq[k].filled = 1'b1;
            mq[k].data   = memRespData;
            break;
          end
        end
      end
    end
    if (flush) begin
      unfilled = 0;
      foreach (mq[k]) if (!mq[k].filled) unfilled++;
      m_drop += unfilled;
      mq.delete();
      case (pcOp)
        2'd2:    tgt = pcBase + pcWriteData;
        2'd3:    tgt = pcWriteData;
        default: tgt = 32'd0;
      endcase
      m_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (exp_iv && instrReady) void'(mq.pop_front());
      if (exp_rv && memReqReady) begin
        mq.push_back('{pc: m_pc, data: 32'd0, filled: 1'b0});
        mem_fifo.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input int pct);
    if (mem_fifo.size() > 0 && $urandom_range(99) < pct) begin
      memRespValid = 1'b1;
      memRespData  = mem_fifo[0] ^ TAG;
    end else begin
      memRespValid = 1'b0;
      memRespData  = $urandom;
    end
  endtask

  task automatic idle_inputs();
    pcOpValid = 1'b0; pcOp = 2'd0; pcBase = 32'd0; pcWriteData = 32'd0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespData = 32'd0; instrReady = 1'b0;
  endtask

  // Drops reset between clock edges and checks the outputs clear without a clock.
  task automatic async_reset_check(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, "_rst_reqValid"}, {31'd0, memReqValid}, 32'd0);
    chk({tag, "_rst_instrValid"}, {31'd0, instrValid}, 32'd0);
    chk({tag, "_rst_instr"}, instr, 32'd0);
    chk({tag, "_rst_instrPc"}, instrPc, 32'd0);
    chk({tag, "_rst_pcRead"}, pcReadData, RESET_PC);
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_clear();
    dut_accepts = 0;
    last_acc_addr = 32'd0;

    tbl[0]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0);
    tbl[3]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h4);
    tbl[4]  = mk(1'b1, 2'd2, 32'h8, 32'h20,  1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 1'b1, 32'h28,  1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 1'b1, 32'h2C,  1'b0, 32'h0);
    tbl[7]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h28,  1'b1, 1'b1, 32'h30,  1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h2C,  1'b1, 1'b1, 32'h34,  1'b1, 32'h28);
    tbl[9]  = mk(1'b1, 2'd1, 32'h0, 32'h0,   1'b1, 1'b1, 32'h30,  1'b1, 1'b0, 32'h38,  1'b0, 32'h0);
    tbl[10] = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h38,  1'b1, 32'h2C);
    tbl[11] = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h3C,  1'b1, 32'h2C);
    tbl[12] = mk(1'b1, 2'd3, 32'h0, 32'h103, 1'b1, 1'b1, 32'h34,  1'b0, 1'b0, 32'h3C,  1'b0, 32'h0);
    tbl[13] = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    tbl[14] = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h38,  1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
    tbl[15] = mk(1'b1, 2'd0, 32'h0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h108, 1'b0, 32'h0);
    tbl[16] = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    tbl[17] = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    tbl[18] = mk(1'b0, 2'd0, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_reqValid", {31'd0, memReqValid}, 32'd0);
    chk("reset_instrValid", {31'd0, instrValid}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_instrPc", instrPc, 32'd0);
    chk("reset_pcRead", pcReadData, RESET_PC);
    reset = 1'b1;

    // Directed table: streaming, redirect flush with drops, PCAdd4, full queue, PCSetImm, PCClear.
    for (int i = 0; i < 19; i++) begin
      pcOpValid = tbl[i].ov; pcOp = tbl[i].op; pcBase = tbl[i].base; pcWriteData = tbl[i].wd;
      memReqReady = tbl[i].mrdy; memRespValid = tbl[i].rv;
      memRespData = tbl[i].raddr ^ TAG; instrReady = tbl[i].irdy;
      #3;
      chk($sformatf("tbl%0d_reqValid", i), {31'd0, memReqValid}, {31'd0, tbl[i].e_rv});
      chk($sformatf("tbl%0d_reqAddr", i), memReqAddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_pcRead", i), pcReadData, tbl[i].e_addr);
      chk($sformatf("tbl%0d_instrValid", i), {31'd0, instrValid}, {31'd0, tbl[i].e_iv});
      if (tbl[i].e_iv) begin
        chk($sformatf("tbl%0d_instrPc", i), instrPc, tbl[i].e_ipc);
        chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_ipc ^ TAG);
      end
      @(posedge clk);
      #1;
    end

    async_reset_check("mid");

    // Decode stalled: exactly DEPTH requests, then one pop frees exactly one credit.
    dut_accepts = 0;
    instrReady = 1'b0; memReqReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_mem(100);
      cycle();
    end
    chk("full_accepts", dut_accepts, 32'd4);
    chk("full_reqValid", {31'd0, memReqValid}, 32'd0);
    instrReady = 1'b1; drive_mem(100);
    cycle();
    instrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_mem(100);
      cycle();
    end
    chk("full_pop_accepts", dut_accepts, 32'd5);
    chk("full_pop_addr", last_acc_addr, 32'h10);

    async_reset_check("full");

    // First request after reset is RESET_PC; then wrap from the top of the address space.
    memReqReady = 1'b1; instrReady = 1'b1; drive_mem(100);
    cycle();
    chk("post_reset_addr", last_acc_addr, RESET_PC);
    pcOpValid = 1'b1; pcOp = 2'd3; pcWriteData = 32'hFFFF_FFF9; drive_mem(100);
    cycle();
    pcOpValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_mem(100);
      cycle();
    end
    chk("wrap_pcRead", pcReadData, 32'h0000_0000);
    for (int i = 0; i < 4; i++) begin
      drive_mem(100);
      cycle();
    end

    // Response with nothing outstanding must be ignored.
    async_reset_check("spur");
    memReqReady = 1'b0; memRespValid = 1'b1; memRespData = 32'hDEAD_BEEF;
    cycle();
    memRespValid = 1'b0;
    cycle();
    chk("spurious_instrValid", {31'd0, instrValid}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pcOpValid   = ($urandom_range(11) == 0);
      pcOp        = 2'($urandom_range(3));
      pcBase      = $urandom;
      pcWriteData = $urandom;
      memReqReady = ($urandom_range(3) != 0);
      instrReady  = ($urandom_range(2) != 0);
      if (mem_fifo.size() > 0) drive_mem(65);
      else begin
        memRespValid = ($urandom_range(7) == 0);
        memRespData  = $urandom;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
